// File: rtl/comparator_mux_pipe.sv
// Registered multi-channel comparator / mux with valid-ready handshakes.
// Modes: MUX pass-through, EQ compare, GT compare, and sequential MAX scan.
// A saturating counter tracks EQ/GT results that had at least one hit.
module comparator_mux_pipe #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_WIDTH  = 8,
  localparam int unsigned IDX_W     = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_input,
  input  logic [DATA_WIDTH-1:0]        compare_value,
  input  logic [1:0]                   mode,
  input  logic [IDX_W-1:0]             sel,
  input  logic                         count_clr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        mux_output,
  output logic [NUM_CH-1:0]            match_mask,
  output logic [IDX_W-1:0]             match_idx,
  output logic [CNT_WIDTH-1:0]         match_count
);

  localparam int unsigned BUS_W = NUM_CH * DATA_WIDTH;

  localparam logic [1:0] MODE_MUX = 2'b00;
  localparam logic [1:0] MODE_EQ  = 2'b01;
  localparam logic [1:0] MODE_GT  = 2'b10;
  localparam logic [1:0] MODE_MAX = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [BUS_W-1:0]       shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0]  best_q, best_d;
  logic [IDX_W-1:0]       best_idx_q, best_idx_d;
  logic [IDX_W-1:0]       scan_idx_q, scan_idx_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  mux_q, mux_d;
  logic [NUM_CH-1:0]      mask_q, mask_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;

  logic [DATA_WIDTH-1:0]  res_mux;
  logic [NUM_CH-1:0]      res_mask;
  logic [IDX_W-1:0]       res_idx;
  logic [DATA_WIDTH-1:0]  scan_ch;
  logic                   slot_free;
  logic                   accept;

  // Handshake: a result slot is free when empty or being drained this edge.
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == ST_IDLE) && slot_free;
  assign accept    = in_valid && in_ready;

  // Single-cycle MUX/EQ/GT result computed from the live inputs.
  always_comb begin
    res_mux  = '0;
    res_mask = '0;
    res_idx  = '0;
    case (mode)
      MODE_MUX: begin
        // An out-of-range select matches no channel and yields all zeros.
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (sel == IDX_W'(i)) begin
            res_mux     = data_input[i*DATA_WIDTH +: DATA_WIDTH];
            res_mask[i] = 1'b1;
            res_idx     = sel;
          end
        end
      end
      MODE_EQ, MODE_GT: begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (mode == MODE_EQ) begin
            res_mask[i] = (data_input[i*DATA_WIDTH +: DATA_WIDTH] == compare_value);
          end else begin
            res_mask[i] = (data_input[i*DATA_WIDTH +: DATA_WIDTH] > compare_value);
          end
        end
        // Walk downward so the lowest matching channel is the last one written.
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
          if (res_mask[i]) begin
            res_mux = data_input[i*DATA_WIDTH +: DATA_WIDTH];
            res_idx = IDX_W'(i);
          end
        end
      end
      default: ;
    endcase
  end

  // Channel currently visited by the MAX scan, taken from the captured copy.
  always_comb begin
    scan_ch = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        scan_ch = shadow_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and result-register update.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    scan_idx_d  = scan_idx_q;
    out_valid_d = out_valid_q;
    mux_d       = mux_q;
    mask_d      = mask_q;
    idx_d       = idx_q;
    count_d     = count_q;

    // Drain; a load below may refill on the same edge.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (mode == MODE_MAX) begin
            shadow_d   = data_input;
            best_d     = data_input[DATA_WIDTH-1:0];
            best_idx_d = '0;
            scan_idx_d = IDX_W'(1);
            state_d    = ST_SCAN;
          end else begin
            out_valid_d = 1'b1;
            mux_d       = res_mux;
            mask_d      = res_mask;
            idx_d       = res_idx;
            if ((mode != MODE_MUX) && (|res_mask) && (count_q != '1)) begin
              count_d = count_q + CNT_WIDTH'(1);
            end
          end
        end
      end
      ST_SCAN: begin
        // Strict compare keeps the earliest index on ties.
        if (scan_ch > best_q) begin
          best_d     = scan_ch;
          best_idx_d = scan_idx_q;
        end
        if (scan_idx_q == IDX_W'(NUM_CH - 1)) begin
          state_d = ST_DONE;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          mux_d       = best_q;
          idx_d       = best_idx_q;
          for (int i = 0; i < int'(NUM_CH); i++) begin
            mask_d[i] = (best_idx_q == IDX_W'(i));
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear has priority over any coincident increment.
    if (count_clr) begin
      count_d = '0;
    end
  end

  // State and result registers; reset discards any in-flight scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      scan_idx_q  <= '0;
      out_valid_q <= 1'b0;
      mux_q       <= '0;
      mask_q      <= '0;
      idx_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      scan_idx_q  <= scan_idx_d;
      out_valid_q <= out_valid_d;
      mux_q       <= mux_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign mux_output  = mux_q;
  assign match_mask  = mask_q;
  assign match_idx   = idx_q;
  assign match_count = count_q;

endmodule
